// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO target: oversamples MDC/MDIO, decodes frames for PHY_ADDR, strobes a local register port.
// Strobes 1 clk after the deciding MDC rise; read data driven on MDC falls; no backpressure on the register port.
module mdio_phy_responder #(
    parameter logic [4:0] PHY_ADDR     = 5'd1,
    parameter int         PREAMBLE_LEN = 32,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic        clk_50_max10,
    input  logic        fpga_resetn,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    output logic [4:0]  reg_addr,
    output logic        reg_rd,
    input  logic [15:0] reg_rd_data,
    output logic        reg_wr,
    output logic [15:0] reg_wr_data,
    output logic        busy,
    output logic        frame_err
);

    localparam int             CW      = $clog2(PREAMBLE_LEN + 1);
    localparam logic [CW-1:0]  PRE_MAX = CW'(PREAMBLE_LEN);

    typedef enum logic [2:0] {
        S_PRE,
        S_ST,
        S_OP,
        S_PA,
        S_RA,
        S_RD,
        S_WR_TA,
        S_WR_DATA
    } state_t;

    // Synchronizers reset to 1 so an idle-high bus does not fake a rise after reset.
    logic [SYNC_STAGES-1:0] r_mdc_sync;
    logic [SYNC_STAGES-1:0] r_mdio_sync;
    logic                   r_mdc_prev;

    logic w_mdc;
    logic w_mdio;
    logic w_rise;
    logic w_fall;

    assign w_mdc  = r_mdc_sync[SYNC_STAGES-1];
    assign w_mdio = r_mdio_sync[SYNC_STAGES-1];
    assign w_rise = w_mdc & ~r_mdc_prev;
    assign w_fall = ~w_mdc & r_mdc_prev;

    always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
        if (!fpga_resetn) begin
            r_mdc_sync  <= '1;
            r_mdio_sync <= '1;
            r_mdc_prev  <= 1'b1;
        end else begin
            r_mdc_sync  <= {r_mdc_sync[SYNC_STAGES-2:0], mdc};
            r_mdio_sync <= {r_mdio_sync[SYNC_STAGES-2:0], mdio_in};
            r_mdc_prev  <= w_mdc;
        end
    end

    state_t         r_state;
    logic [CW-1:0]  r_pre_cnt;
    logic [3:0]     r_bcnt;
    logic [4:0]     r_fcnt;
    logic           r_op_msb;
    logic           r_is_read;
    logic [4:0]     r_pa;
    logic [4:0]     r_ra;
    logic [15:0]    r_shift;
    logic           r_mdio_out;
    logic           r_mdio_oen;
    logic [4:0]     r_reg_addr;
    logic           r_reg_rd;
    logic           r_reg_wr;
    logic [15:0]    r_reg_wr_data;
    logic           r_busy;
    logic           r_frame_err;

    logic [4:0]     w_ra_next;
    logic [15:0]    w_shift_in;

    assign w_ra_next  = {r_ra[3:0], w_mdio};
    assign w_shift_in = {r_shift[14:0], w_mdio};

    always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
        if (!fpga_resetn) begin
            r_state       <= S_PRE;
            r_pre_cnt     <= '0;
            r_bcnt        <= '0;
            r_fcnt        <= '0;
            r_op_msb      <= 1'b0;
            r_is_read     <= 1'b0;
            r_pa          <= '0;
            r_ra          <= '0;
            r_shift       <= '0;
            r_mdio_out    <= 1'b1;
            r_mdio_oen    <= 1'b1;
            r_reg_addr    <= '0;
            r_reg_rd      <= 1'b0;
            r_reg_wr      <= 1'b0;
            r_reg_wr_data <= '0;
            r_busy        <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_reg_rd    <= 1'b0;
            r_reg_wr    <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_state)
                S_PRE: begin
                    if (w_rise) begin
                        if (w_mdio) begin
                            if (r_pre_cnt != PRE_MAX) begin
                                r_pre_cnt <= r_pre_cnt + 1'b1;
                            end
                        end else if (r_pre_cnt == PRE_MAX) begin
                            // This 0 is the first ST bit.
                            r_state   <= S_ST;
                            r_busy    <= 1'b1;
                            r_pre_cnt <= '0;
                        end else begin
                            r_pre_cnt <= '0;
                        end
                    end
                end

                S_ST: begin
                    if (w_rise) begin
                        if (w_mdio) begin
                            r_state <= S_OP;
                            r_bcnt  <= '0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_PRE;
                            r_busy      <= 1'b0;
                            r_pre_cnt   <= '0;
                        end
                    end
                end

                S_OP: begin
                    if (w_rise) begin
                        if (r_bcnt == 4'd0) begin
                            r_op_msb <= w_mdio;
                            r_bcnt   <= 4'd1;
                        end else if ({r_op_msb, w_mdio} == 2'b10 || {r_op_msb, w_mdio} == 2'b01) begin
                            r_is_read <= r_op_msb;
                            r_state   <= S_PA;
                            r_bcnt    <= '0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_PRE;
                            r_busy      <= 1'b0;
                            r_pre_cnt   <= '0;
                        end
                    end
                end

                S_PA: begin
                    if (w_rise) begin
                        r_pa <= {r_pa[3:0], w_mdio};
                        if (r_bcnt == 4'd4) begin
                            r_state <= S_RA;
                            r_bcnt  <= '0;
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                end

                S_RA: begin
                    if (w_rise) begin
                        r_ra <= w_ra_next;
                        if (r_bcnt == 4'd4) begin
                            r_reg_addr <= w_ra_next;
                            r_bcnt     <= '0;
                            r_fcnt     <= '0;
                            if (r_pa != PHY_ADDR) begin
                                r_state   <= S_PRE;
                                r_busy    <= 1'b0;
                                r_pre_cnt <= '0;
                            end else if (r_is_read) begin
                                r_reg_rd <= 1'b1;
                                r_state  <= S_RD;
                            end else begin
                                r_state <= S_WR_TA;
                            end
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                end

                S_RD: begin
                    // r_fcnt holds the number of falls already seen since the last RA rise.
                    if (r_reg_rd) begin
                        r_shift <= reg_rd_data;
                    end else if (w_fall) begin
                        r_fcnt <= r_fcnt + 1'b1;
                        if (r_fcnt == 5'd1) begin
                            r_mdio_oen <= 1'b0;
                            r_mdio_out <= 1'b0;
                        end else if (r_fcnt >= 5'd2 && r_fcnt <= 5'd17) begin
                            r_mdio_out <= r_shift[15];
                            r_shift    <= {r_shift[14:0], 1'b0};
                        end else if (r_fcnt == 5'd18) begin
                            r_mdio_oen <= 1'b1;
                            r_mdio_out <= 1'b1;
                            r_state    <= S_PRE;
                            r_busy     <= 1'b0;
                            r_pre_cnt  <= '0;
                        end
                    end
                end

                S_WR_TA: begin
                    if (w_rise) begin
                        if (r_bcnt == 4'd1) begin
                            r_state <= S_WR_DATA;
                            r_bcnt  <= '0;
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                end

                S_WR_DATA: begin
                    if (w_rise) begin
                        r_shift <= w_shift_in;
                        if (r_bcnt == 4'd15) begin
                            r_reg_wr_data <= w_shift_in;
                            r_reg_wr      <= 1'b1;
                            r_state       <= S_PRE;
                            r_busy        <= 1'b0;
                            r_pre_cnt     <= '0;
                            r_bcnt        <= '0;
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state    <= S_PRE;
                    r_busy     <= 1'b0;
                    r_pre_cnt  <= '0;
                    r_mdio_oen <= 1'b1;
                    r_mdio_out <= 1'b1;
                end
            endcase
        end
    end

    assign mdio_out    = r_mdio_out;
    assign mdio_oen    = r_mdio_oen;
    assign reg_addr    = r_reg_addr;
    assign reg_rd      = r_reg_rd;
    assign reg_wr      = r_reg_wr;
    assign reg_wr_data = r_reg_wr_data;
    assign busy        = r_busy;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: acts as the MDC/MDIO master and checks strobes and bus drive.
module tb_mdio_phy_responder;

    logic        clk_50_max10 = 1'b0;
    logic        fpga_resetn;
    logic        mdc;
    logic        mdio_in;
    logic        mdio_out;
    logic        mdio_oen;
    logic [4:0]  reg_addr;
    logic        reg_rd;
    logic [15:0] reg_rd_data;
    logic        reg_wr;
    logic [15:0] reg_wr_data;
    logic        busy;
    logic        frame_err;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    mdio_phy_responder #(
        .PHY_ADDR     (5'd1),
        .PREAMBLE_LEN (32),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_50_max10 (clk_50_max10),
        .fpga_resetn  (fpga_resetn),
        .mdc          (mdc),
        .mdio_in      (mdio_in),
        .mdio_out     (mdio_out),
        .mdio_oen     (mdio_oen),
        .reg_addr     (reg_addr),
        .reg_rd       (reg_rd),
        .reg_rd_data  (reg_rd_data),
        .reg_wr       (reg_wr),
        .reg_wr_data  (reg_wr_data),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    always #10 clk_50_max10 = ~clk_50_max10;

    // Cumulative event monitor; tests compare deltas.
    int          n_rd = 0, n_wr = 0, n_err = 0, n_oenlo = 0, n_busy = 0, n_both = 0;
    logic [4:0]  mon_rd_addr = '0, mon_wr_addr = '0;
    logic [15:0] mon_wr_data = '0;

    always @(negedge clk_50_max10) begin
        if (reg_rd) begin n_rd++; mon_rd_addr = reg_addr; end
        if (reg_wr) begin n_wr++; mon_wr_addr = reg_addr; mon_wr_data = reg_wr_data; end
        if (reg_rd && reg_wr) n_both++;
        if (frame_err) n_err++;
        if (!mdio_oen) n_oenlo++;
        if (busy) n_busy++;
    end

    // One MDC period, 6 clk low then 6 clk high; bus sampled just before the rise.
    task automatic mdc_bit(input logic b, output logic so, output logic soen);
        mdio_in = b;
        repeat (6) @(negedge clk_50_max10);
        so   = mdio_out;
        soen = mdio_oen;
        mdc  = 1'b1;
        repeat (6) @(negedge clk_50_max10);
        mdc = 1'b0;
    endtask

    task automatic send_field(input logic [15:0] v, input int n);
        logic so, soen;
        for (int i = n - 1; i >= 0; i--) mdc_bit(v[i], so, soen);
    endtask

    task automatic send_pre(input int n);
        for (int i = 0; i < n; i++) send_field(16'h1, 1);
    endtask

    task automatic send_header(input int npre, input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra);
        send_pre(npre);
        send_field(16'h1, 2);
        send_field({14'd0, op}, 2);
        send_field({11'd0, pa}, 5);
        send_field({11'd0, ra}, 5);
    endtask

    // 19 bus samples after the RA bits: oen per sample, bus value of data samples 2..17.
    task automatic read_tail(output logic [15:0] word, output logic [18:0] oenv, output logic out1);
        logic so, soen;
        word = '0;
        out1 = 1'b1;
        for (int i = 0; i < 19; i++) begin
            mdc_bit(1'b1, so, soen);
            oenv[i] = soen;
            if (i == 1) out1 = so;
            if (i >= 2 && i <= 17) word = {word[14:0], soen ? 1'b1 : so};
        end
    endtask

    task automatic do_reset();
        fpga_resetn = 1'b0;
        repeat (3) @(negedge clk_50_max10);
        fpga_resetn = 1'b1;
        repeat (3) @(negedge clk_50_max10);
    endtask

    task automatic test_reset();
        fpga_resetn = 1'b0;
        mdc         = 1'b0;
        mdio_in     = 1'b1;
        reg_rd_data = '0;
        repeat (5) @(negedge clk_50_max10);
        chk_cnt++;
        if ({mdio_oen, mdio_out} !== 2'b11) $display("FAIL reset_pad: got oen/out=%b, want 11", {mdio_oen, mdio_out});
        else pass_cnt++;
        chk_cnt++;
        if ({reg_rd, reg_wr, busy, frame_err} !== 4'b0000) $display("FAIL reset_flags: got rd/wr/busy/err=%b, want 0000", {reg_rd, reg_wr, busy, frame_err});
        else pass_cnt++;
        chk_cnt++;
        if (reg_addr !== 5'd0 || reg_wr_data !== 16'd0) $display("FAIL reset_regs: got addr=%h wdata=%h, want 00 0000", reg_addr, reg_wr_data);
        else pass_cnt++;
        fpga_resetn = 1'b1;
        repeat (3) @(negedge clk_50_max10);
    endtask

    task automatic test_write();
        int wr0 = n_wr, rd0 = n_rd, oen0 = n_oenlo, err0 = n_err;
        send_header(32, 2'b01, 5'd1, 5'h04);
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL write_busy_mid: got %b, want 1", busy);
        else pass_cnt++;
        send_field(16'h2, 2);
        send_field(16'hA5C3, 16);
        chk_cnt++;
        if (n_wr - wr0 !== 1 || n_rd - rd0 !== 0) $display("FAIL write_strobes: got wr=%0d rd=%0d, want 1 0", n_wr - wr0, n_rd - rd0);
        else pass_cnt++;
        chk_cnt++;
        if (mon_wr_addr !== 5'h04 || mon_wr_data !== 16'hA5C3) $display("FAIL write_data: got addr=%h data=%h, want 04 a5c3", mon_wr_addr, mon_wr_data);
        else pass_cnt++;
        chk_cnt++;
        if (n_oenlo - oen0 !== 0 || n_err - err0 !== 0) $display("FAIL write_quiet: got oen_low=%0d err=%0d, want 0 0", n_oenlo - oen0, n_err - err0);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL write_busy_end: got %b, want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_read();
        logic [15:0] word;
        logic [18:0] oenv;
        logic        out1;
        int rd0 = n_rd, wr0 = n_wr;
        reg_rd_data = 16'h1234;
        send_header(32, 2'b10, 5'd1, 5'h02);
        read_tail(word, oenv, out1);
        chk_cnt++;
        if (n_rd - rd0 !== 1 || n_wr - wr0 !== 0 || mon_rd_addr !== 5'h02) $display("FAIL read_strobe: got rd=%0d wr=%0d addr=%h, want 1 0 02", n_rd - rd0, n_wr - wr0, mon_rd_addr);
        else pass_cnt++;
        chk_cnt++;
        if (oenv !== 19'h40001) $display("FAIL read_oen_window: got %h, want 40001", oenv);
        else pass_cnt++;
        chk_cnt++;
        if (out1 !== 1'b0) $display("FAIL read_ta_zero: got %b, want 0", out1);
        else pass_cnt++;
        chk_cnt++;
        if (word !== 16'h1234) $display("FAIL read_data: got %h, want 1234", word);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL read_busy_end: got %b, want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_pa_mismatch();
        logic [15:0] word;
        logic [18:0] oenv;
        logic        out1;
        int rd0 = n_rd, oen0 = n_oenlo, err0 = n_err;
        send_header(32, 2'b10, 5'd3, 5'h02);
        read_tail(word, oenv, out1);
        chk_cnt++;
        if (n_rd - rd0 !== 0 || n_oenlo - oen0 !== 0) $display("FAIL pa_mismatch_silent: got rd=%0d oen_low=%0d, want 0 0", n_rd - rd0, n_oenlo - oen0);
        else pass_cnt++;
        chk_cnt++;
        if (n_err - err0 !== 0 || busy !== 1'b0) $display("FAIL pa_mismatch_err: got err=%0d busy=%b, want 0 0", n_err - err0, busy);
        else pass_cnt++;
    endtask

    task automatic test_short_preamble();
        logic [15:0] word;
        logic [18:0] oenv;
        logic        out1;
        int rd0, busy0;
        do_reset();
        rd0 = n_rd;
        busy0 = n_busy;
        send_header(31, 2'b10, 5'd1, 5'h02);
        read_tail(word, oenv, out1);
        chk_cnt++;
        if (n_rd - rd0 !== 0 || n_busy - busy0 !== 0) $display("FAIL short_pre_ignored: got rd=%0d busy_cycles=%0d, want 0 0", n_rd - rd0, n_busy - busy0);
        else pass_cnt++;
        reg_rd_data = 16'hBEEF;
        send_header(32, 2'b10, 5'd1, 5'h02);
        read_tail(word, oenv, out1);
        chk_cnt++;
        if (n_rd - rd0 !== 1 || word !== 16'hBEEF) $display("FAIL full_pre_accepted: got rd=%0d data=%h, want 1 beef", n_rd - rd0, word);
        else pass_cnt++;
    endtask

    task automatic test_bad_opcode();
        int err0 = n_err, wr0;
        send_pre(32);
        send_field(16'h1, 2);
        send_field(16'h3, 2);
        chk_cnt++;
        if (n_err - err0 !== 1 || busy !== 1'b0) $display("FAIL bad_op_err: got err=%0d busy=%b, want 1 0", n_err - err0, busy);
        else pass_cnt++;
        wr0 = n_wr;
        send_header(32, 2'b01, 5'd1, 5'h1F);
        send_field(16'h2, 2);
        send_field(16'h5A0F, 16);
        chk_cnt++;
        if (n_wr - wr0 !== 1 || mon_wr_addr !== 5'h1F || mon_wr_data !== 16'h5A0F) $display("FAIL bad_op_recover: got wr=%0d addr=%h data=%h, want 1 1f 5a0f", n_wr - wr0, mon_wr_addr, mon_wr_data);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        logic        so, soen;
        logic [15:0] word;
        logic [18:0] oenv;
        logic        out1;
        int wr0 = n_wr, rd0;
        reg_rd_data = 16'hC0DE;
        send_header(32, 2'b10, 5'd1, 5'h05);
        for (int i = 0; i < 9; i++) mdc_bit(1'b1, so, soen);
        repeat (4) @(negedge clk_50_max10);
        chk_cnt++;
        if (mdio_oen !== 1'b0) $display("FAIL midframe_driving: got oen=%b, want 0", mdio_oen);
        else pass_cnt++;
        fpga_resetn = 1'b0;
        #1;
        chk_cnt++;
        if ({mdio_oen, mdio_out, busy} !== 3'b110) $display("FAIL midframe_async: got oen/out/busy=%b, want 110", {mdio_oen, mdio_out, busy});
        else pass_cnt++;
        repeat (4) @(negedge clk_50_max10);
        fpga_resetn = 1'b1;
        repeat (4) @(negedge clk_50_max10);
        chk_cnt++;
        if (n_wr - wr0 !== 0) $display("FAIL midframe_no_wr: got wr=%0d, want 0", n_wr - wr0);
        else pass_cnt++;
        rd0 = n_rd;
        reg_rd_data = 16'h0F5A;
        send_header(32, 2'b10, 5'd1, 5'h06);
        read_tail(word, oenv, out1);
        chk_cnt++;
        if (n_rd - rd0 !== 1 || word !== 16'h0F5A || oenv !== 19'h40001) $display("FAIL post_reset_read: got rd=%0d data=%h oen=%h, want 1 0f5a 40001", n_rd - rd0, word, oenv);
        else pass_cnt++;
        chk_cnt++;
        if (n_both !== 0) $display("FAIL rd_wr_exclusive: got %0d overlapping cycles, want 0", n_both);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_pa_mismatch();
        test_short_preamble();
        test_bad_opcode();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- PHY-side IEEE 802.3 Clause 22 MDIO management responder: the target end of the MDC/MDIO bus the TSE MAC masters.
- Oversamples MDC and MDIO on the 50 MHz system clock and decodes read/write frames addressed to its PHY address.
- Exposes a simple register-port to a local 32x16 register bank, and drives read data back onto the bus through an active-low output enable, matching the MAC-side mdio_out/mdio_oen convention.
- Used for on-board PHY emulation and for loopback verification of the management path.

Parameters:
- PHY_ADDR, 5'd1, PHY address this block answers to.
- PREAMBLE_LEN, 32, consecutive MDIO '1' bits required before ST is accepted; range 1..32.
- SYNC_STAGES, 2, synchronizer depth for mdc and mdio_in; minimum 2.

Ports:
- clk_50_max10  in  1  system clock, 50 MHz.
- fpga_resetn  in  1  asynchronous active-low reset.
- mdc  in  1  management clock from the MAC, asynchronous to clk_50_max10.
- mdio_in  in  1  MDIO pad input.
- mdio_out  out  1  MDIO drive value.
- mdio_oen  out  1  output enable, active low; pad is driven only when 0.
- reg_addr  out  5  register address, held stable from REGAD capture until the frame ends.
- reg_rd  out  1  one-cycle read strobe.
- reg_rd_data  in  16  read data, sampled exactly 1 clk after reg_rd.
- reg_wr  out  1  one-cycle write strobe.
- reg_wr_data  out  16  write data, valid while reg_wr is high.
- busy  out  1  frame in progress (ST accepted, return to PRE not yet taken).
- frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Clock and reset: one clock, clk_50_max10. fpga_resetn is asynchronous, active-low.
- Reset values: mdio_oen=1, mdio_out=1, reg_rd=0, reg_wr=0, reg_addr=0, reg_wr_data=0, busy=0, frame_err=0, state=PRE, preamble count=0.
- Synchronization: mdc and mdio_in each pass through SYNC_STAGES flops. rise = sync_mdc & !prev_mdc; fall = !sync_mdc & prev_mdc.
- Sampling and drive: MDIO is sampled only on rise and driven/changed only on fall.
- MDC limits: frequency <= 12.5 MHz; high and low phases >= 2 clk each. Behaviour outside these limits is undefined.
- PRE: each sampled 1 increments the count, saturating at PREAMBLE_LEN.
  - Sampled 0 with count < PREAMBLE_LEN: count cleared, stay in PRE.
  - Sampled 0 with count == PREAMBLE_LEN: treated as ST bit 0, go to ST, busy=1.
- ST: sampled 1 goes to OP. Sampled 0 pulses frame_err and goes to PRE.
- OP: two bits, MSB first. 10 = read, 01 = write. 00 or 11 pulses frame_err and goes to PRE.
- PA: 5 bits, MSB first.
- RA: 5 bits, MSB first; reg_addr updates on the 5th rise.
  - PA != PHY_ADDR: go to PRE silently (no strobes, no drive, no error); busy=0 on the next clk.
  - Read: reg_rd pulses on the clk after the 5th RA rise; reg_rd_data is latched into the shift register on the following clk.
- Read turnaround and data (falls counted after the last RA rise):
  - F1: mdio_oen stays 1 (TA bit 1 = Z).
  - F2: mdio_oen=0, mdio_out=0.
  - F3..F18: mdio_out = data[15] down to data[0].
  - F19: mdio_oen=1, mdio_out=1, go to PRE, busy=0.
- Write: two TA rises are sampled but not checked; then 16 data rises shift in MSB first. On the clk after the 16th data rise, reg_wr pulses with reg_wr_data and reg_addr valid; go to PRE, busy=0.
- Exclusivity: reg_rd and reg_wr never assert in the same frame, nor in the same cycle.
- Preamble count: cleared on every return to PRE.
- Reset mid-frame: all outputs return to reset values asynchronously; mdio_oen=1 immediately; no strobe is issued for the aborted frame.
- Frame restart: any frame begun after a reset or error requires a full PREAMBLE_LEN preamble.

Test Plan:
- Write to PA=1, RA=0x04, data 0xA5C3 after 32 ones -> exactly one reg_wr, reg_addr=0x04, reg_wr_data=0xA5C3; mdio_oen=1 for the whole frame; busy drops after the strobe.
- Read of RA=0x02 with reg_rd_data=0x1234 -> one reg_rd, reg_addr=0x02. Bus shows Z on F1, 0 on F2, then 0001_0010_0011_0100 MSB first on F3..F18. mdio_oen=1 again from F19.
- Read of PA=3 (mismatch) -> no reg_rd, mdio_oen never 0, frame_err=0.
- 31 ones, then 0, 1, read opcode for PA=1 -> frame ignored, no strobe. The same frame repeated with 32 ones -> accepted.
- Opcode 11 after a valid preamble and ST -> frame_err pulses once, busy=0; the next valid write is accepted normally.
- fpga_resetn asserted at F10 of a read -> mdio_oen=1 and mdio_out=1 within the reset assertion, busy=0, no reg_wr; a following full read returns correct data.
